pathcount_collector: RTL
========================

// Module: pathcount_collector
// PURPOSE
//  Parametrised result-collection and completion stage for the node network.
//  Watches the accepted-request stream leaving the request switch and the per-nodeset
//  completion flags. Accumulates path counts for up to NUM_TARGETS registered end nodes.
//  Declares the count final only after all nodesets are complete and the network has been quiet.
//  Replaces the fixed 64-set, single-target listener and completion reduction.
// PARAMETERS
//  NUM_SETS      64  number of nodesets / switch output channels; power of 2, >=2
//  LOCAL_W       6   width of the node index within a nodeset
//  NUM_PATHS_DW  16  width of path counts and accumulators
//  NUM_TARGETS   2   number of end-node registers / accumulators, >=1
//  QUIET_CYCLES  4   consecutive quiet cycles required before declaring done, >=1
//  (derived) SET_W = $clog2(NUM_SETS); TAG_W = SET_W + LOCAL_W
// PORTS
//  clk              in   1                          clock
//  rst              in   1                          asynchronous active-high reset
//  i_node_tag       in   TAG_W                      node tag {set index, local index}
//  i_node_tag_vld   in   1                          i_node_tag valid
//  i_endnode        in   1                          qualifies i_node_tag as a target end node
//  i_start_counting in   1                          pulse: IDLE -> COUNT
//  i_clear          in   1                          pulse: drop targets and results, go to IDLE
//  i_set_done       in   NUM_SETS                   per-nodeset "all reqs complete"
//  i_req_vld        in   NUM_SETS                   per-channel accepted request (already vld & ack)
//  i_req_paths      in   NUM_SETS*NUM_PATHS_DW      flat; channel c at [c*DW +: DW]
//  i_req_nodenum    in   NUM_SETS*LOCAL_W           flat; local node index of channel c
//  o_reqs_complete  out  1                          registered AND of i_set_done
//  o_num_targets    out  $clog2(NUM_TARGETS+1)      number of registered targets
//  o_num_paths      out  NUM_TARGETS*NUM_PATHS_DW   accumulator t at [t*DW +: DW]
//  o_overflow       out  NUM_TARGETS                sticky saturation flag per target
//  o_num_paths_vld  out  1                          results final (high only in DONE)
// BEHAVIOUR
//  Reset: state IDLE; all outputs and accumulators 0; target slots and quiet counter cleared.
//  FSM states: IDLE, COUNT, DONE. i_clear has priority over every transition and update.
//   - i_clear: next cycle state=IDLE, targets=0, accumulators=0, o_overflow=0.
//   - IDLE -> COUNT on i_start_counting, only if o_num_targets>0; otherwise the pulse is ignored.
//   - COUNT -> DONE when the quiet condition holds for QUIET_CYCLES consecutive cycles.
//     Quiet condition: &i_set_done && ~|i_req_vld.
//   - DONE holds until i_clear; i_start_counting in COUNT/DONE is ignored.
//  Target registration (IDLE only):
//   - On i_endnode & i_node_tag_vld, the tag is written to slot o_num_targets and o_num_targets increments.
//   - Writes when slots are full, or in COUNT/DONE, are dropped.
//   - A duplicate tag occupies its own slot; both slots accumulate identically.
//  Accumulation (COUNT only, including the cycle COUNT->DONE is decided):
//   - Target t with tag {s,n} is hit when i_req_vld[s] and i_req_nodenum[s]==n.
//   - On a hit, acc[t] <= acc[t] + i_req_paths[s], visible on o_num_paths 1 cycle later.
//   - Tag structure allows at most one hit per target per cycle.
//   - Addition saturates at all-ones; the saturating cycle sets o_overflow[t], which stays high until i_clear/rst.
//   - Requests in IDLE or DONE, including the i_start_counting cycle, are not counted.
//  Quiet counter q (width $clog2(QUIET_CYCLES+1)), in COUNT:
//   - q<=0 if the quiet condition fails; otherwise q<=q+1.
//   - Entering DONE when the condition holds and q==QUIET_CYCLES-1.
//   - o_num_paths_vld rises the cycle after the QUIET_CYCLES-th consecutive quiet cycle.
//   - q is cleared on entry to COUNT.
//  o_reqs_complete <= &i_set_done every cycle in all states (1-cycle latency).
//  o_num_paths is always driven from the accumulators; it is valid only while o_num_paths_vld is high.
//  An asynchronous rst mid-COUNT discards all state; no partial result is retained.
// TESTING
//  1. Defaults; register tag 0x041; start; channel 1 nodenum 1 paths 3, then 5 -> o_num_paths[0]=8.
//     Then all i_set_done=1, no vld for 4 cycles -> o_num_paths_vld rises the next cycle.
//  2. Targets 0x041 and 0x7C2; channels 1 and 31 hit them in the same cycle with 7 and 9 -> acc0=7, acc1=9.
//     A hit on channel 1 nodenum 2 is ignored.
//  3. DW=4; one target; hits of 10 and 9 -> o_num_paths[0]=15 and o_overflow[0]=1.
//     After i_clear -> both 0 and state IDLE.
//  4. All done; a vld pulse after 3 quiet cycles -> q restarts and vld rises only after 4 fresh quiet cycles.
//     A request arriving in DONE leaves results unchanged.
//  5. i_start_counting with 0 targets -> stays IDLE.
//     A third registration with NUM_TARGETS=2 -> dropped, o_num_targets=2.
//     A request in the start cycle -> not counted.
//  6. rst asserted asynchronously mid-COUNT with acc0=12 -> all outputs 0 immediately.
//     After release, state IDLE and o_num_targets=0.

Source files
------------

// File: rtl/pathcount_collector.sv
// pathcount_collector
//   Result-collection and completion stage for the node network. Registers up to
//   NUM_TARGETS end-node tags while idle, accumulates the path counts of accepted
//   requests that hit those tags while counting, and declares the result final once
//   every nodeset reports completion and the switch has been quiet for QUIET_CYCLES
//   consecutive cycles.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   i_node_tag*        target registration: tag {set, local}, valid, end-node qualifier
//   i_start_counting   IDLE -> COUNT (ignored with no targets registered)
//   i_clear            drop targets and results, return to IDLE (highest priority)
//   i_set_done         per-nodeset completion flags
//   i_req_vld/paths/nodenum  accepted request stream, one channel per nodeset
//   o_reqs_complete    registered AND of i_set_done
//   o_num_targets      number of registered targets
//   o_num_paths        flat accumulators, target t at [t*DW +: DW]
//   o_overflow         sticky per-target saturation flag
//   o_num_paths_vld    results final (DONE state)
module pathcount_collector #(
    parameter int unsigned NUM_SETS     = 64,
    parameter int unsigned LOCAL_W      = 6,
    parameter int unsigned NUM_PATHS_DW = 16,
    parameter int unsigned NUM_TARGETS  = 2,
    parameter int unsigned QUIET_CYCLES = 4,
    localparam int unsigned SET_W       = $clog2(NUM_SETS),
    localparam int unsigned TAG_W       = SET_W + LOCAL_W,
    localparam int unsigned NT_W        = $clog2(NUM_TARGETS + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [TAG_W-1:0]                    i_node_tag,
    input  logic                                i_node_tag_vld,
    input  logic                                i_endnode,
    input  logic                                i_start_counting,
    input  logic                                i_clear,
    input  logic [NUM_SETS-1:0]                 i_set_done,
    input  logic [NUM_SETS-1:0]                 i_req_vld,
    input  logic [NUM_SETS*NUM_PATHS_DW-1:0]    i_req_paths,
    input  logic [NUM_SETS*LOCAL_W-1:0]         i_req_nodenum,
    output logic                                o_reqs_complete,
    output logic [NT_W-1:0]                     o_num_targets,
    output logic [NUM_TARGETS*NUM_PATHS_DW-1:0] o_num_paths,
    output logic [NUM_TARGETS-1:0]              o_overflow,
    output logic                                o_num_paths_vld
);

    localparam int unsigned DW = NUM_PATHS_DW;
    localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e                  state_q, state_d;
    logic [QW-1:0]           quiet_cnt_q, quiet_cnt_d;
    logic [NT_W-1:0]         num_targets_q, num_targets_d;
    logic [TAG_W-1:0]        tags_q [NUM_TARGETS];
    logic [TAG_W-1:0]        tags_d [NUM_TARGETS];
    logic [DW-1:0]           acc_q  [NUM_TARGETS];
    logic [DW-1:0]           acc_d  [NUM_TARGETS];
    logic [NUM_TARGETS-1:0]  ovf_q, ovf_d;
    logic                    reqs_complete_q, reqs_complete_d;

    logic                    hit       [NUM_TARGETS];
    logic [DW-1:0]           hit_paths [NUM_TARGETS];
    logic [DW:0]             sum       [NUM_TARGETS];
    logic                    quiet;

    assign quiet = (&i_set_done) & ~(|i_req_vld);

    // Per-target hit detection. A tag names exactly one channel, so at most one
    // channel can match per target and the OR-style mux below is unambiguous.
    always_comb begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
            hit[t]       = 1'b0;
            hit_paths[t] = '0;
            for (int c = 0; c < NUM_SETS; c++) begin
                if (i_req_vld[c] &&
                    tags_q[t] == {SET_W'(c), i_req_nodenum[c*LOCAL_W +: LOCAL_W]}) begin
                    hit[t]       = 1'b1;
                    hit_paths[t] = i_req_paths[c*DW +: DW];
                end
            end
            // Unregistered slots hold tag 0 and must never match.
            if (NT_W'(t) >= num_targets_q) begin
                hit[t] = 1'b0;
            end
            sum[t] = {1'b0, acc_q[t]} + {1'b0, hit_paths[t]};
        end
    end

    always_comb begin
        state_d         = state_q;
        quiet_cnt_d     = quiet_cnt_q;
        num_targets_d   = num_targets_q;
        tags_d          = tags_q;
        acc_d           = acc_q;
        ovf_d           = ovf_q;
        reqs_complete_d = &i_set_done;

        if (i_clear) begin
            state_d       = StIdle;
            quiet_cnt_d   = '0;
            num_targets_d = '0;
            ovf_d         = '0;
            for (int t = 0; t < NUM_TARGETS; t++) begin
                tags_d[t] = '0;
                acc_d[t]  = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_endnode && i_node_tag_vld &&
                        num_targets_q < NT_W'(NUM_TARGETS)) begin
                        for (int t = 0; t < NUM_TARGETS; t++) begin
                            if (NT_W'(t) == num_targets_q) begin
                                tags_d[t] = i_node_tag;
                            end
                        end
                        num_targets_d = num_targets_q + NT_W'(1);
                    end
                    if (i_start_counting && num_targets_q != '0) begin
                        state_d     = StCount;
                        quiet_cnt_d = '0;
                    end
                end
                StCount: begin
                    for (int t = 0; t < NUM_TARGETS; t++) begin
                        if (hit[t]) begin
                            if (sum[t][DW]) begin
                                acc_d[t] = '1;
                                ovf_d[t] = 1'b1;
                            end else begin
                                acc_d[t] = sum[t][DW-1:0];
                            end
                        end
                    end
                    if (quiet) begin
                        if (quiet_cnt_q == QW'(QUIET_CYCLES - 1)) begin
                            state_d = StDone;
                        end
                        quiet_cnt_d = quiet_cnt_q + QW'(1);
                    end else begin
                        quiet_cnt_d = '0;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            quiet_cnt_q     <= '0;
            num_targets_q   <= '0;
            ovf_q           <= '0;
            reqs_complete_q <= 1'b0;
            for (int t = 0; t < NUM_TARGETS; t++) begin
                tags_q[t] <= '0;
                acc_q[t]  <= '0;
            end
        end else begin
            state_q         <= state_d;
            quiet_cnt_q     <= quiet_cnt_d;
            num_targets_q   <= num_targets_d;
            ovf_q           <= ovf_d;
            reqs_complete_q <= reqs_complete_d;
            tags_q          <= tags_d;
            acc_q           <= acc_d;
        end
    end

    always_comb begin
        o_num_paths = '0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            o_num_paths[t*DW +: DW] = acc_q[t];
        end
    end

    assign o_reqs_complete = reqs_complete_q;
    assign o_num_targets   = num_targets_q;
    assign o_overflow      = ovf_q;
    assign o_num_paths_vld = (state_q == StDone);

endmodule
